// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial add/subtract controller.
// Optional overflow output is enabled by defining SERIAL_ADD_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width; a 1-bit floor keeps degenerate widths legal.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder written purely with AND gates and inverters,
// so it can be replaced one-for-one by the AOIG benchmark cell.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    logic xy_and;
    logic x_not_y;
    logic y_not_x;
    logic p;
    logic p_not_z;
    logic z_not_p;
    logic pz_and;

    // p = x ^ y, expressed as NOT(NOT(x & ~y) & NOT(~x & y))
    assign x_not_y = x & ~y;
    assign y_not_x = ~x & y;
    assign p       = ~(~x_not_y & ~y_not_x);

    assign p_not_z = p & ~z;
    assign z_not_p = ~p & z;
    assign s       = ~(~p_not_z & ~z_not_p);

    assign xy_and  = x & y;
    assign pz_and  = p & z;
    assign c       = ~(~xy_and & ~pz_and);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract shell around one shared full-adder cell.
// Build option: define SERIAL_ADD_OVF_EN to produce the signed-overflow output.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid holds its payload stable until that edge, and ready never
    // depends combinationally on valid.
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s;
    logic             fa_c;

    fa_cell u_fa (
        .x (a_q[0]),
        .y (b_q[0]),
        .z (carry_q),
        .s (fa_s),
        .c (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B and seed the carry.
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_valid ? sum_q : '0;
    assign out_cout  = out_valid & carry_q;

`ifdef SERIAL_ADD_OVF_EN
    logic cmsb_q, cmsb_d;

    // Carry into the MSB is the one still held while the last bit is processed.
    always_comb begin
        cmsb_d = cmsb_q;
        if (state_q == RUN && cnt_q == LAST_CNT) begin
            cmsb_d = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmsb_q <= 1'b0;
        end else begin
            cmsb_q <= cmsb_d;
        end
    end

    assign out_ovf = out_valid & (cmsb_q ^ carry_q);
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner
// sequences, randomized ops against an arithmetic model, back-to-back stream.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    logic [W+1:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        int unsigned ua;
        int unsigned ub;
        int          sa;
        int          sb;
        int          sres;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (!sub) begin
            sum  = W'((ua + ub) % 256);
            cout = (ua + ub) > 255;
            sres = sa + sb;
        end else begin
            sum  = W'((ua + 256 - ub) % 256);
            cout = (ua >= ub);
            sres = sa - sb;
        end
        ovf = (sres > 127) || (sres < -128);
`ifndef SERIAL_ADD_OVF_EN
        ovf = 1'b0;
`endif
        return {ovf, cout, sum};
    endfunction

    function automatic logic ovf_exp(input logic ovf);
`ifdef SERIAL_ADD_OVF_EN
        return ovf;
`else
        return 1'b0 & ovf;
`endif
    endfunction

    // ---------------- driver ----------------
    // One full operation: offer operands, measure latency, optionally stall the
    // consumer and pulse in_valid while busy, then check and retire the result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W+1:0] exp,
                          input int stall, input bit glitch);
        int lat;
        int waitc;
        logic [W-1:0] held_sum;
        logic         held_cout;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        waitc    = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        // Latency counts the accept edge itself as edge 1.
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (glitch) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = W'($urandom);
                in_b     = W'($urandom);
                in_sub   = 1'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, W + 1);
        check({tag, "_in_ready_done"}, in_ready, 0);
        held_sum  = out_sum;
        held_cout = out_cout;
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_stall_valid"}, out_valid, 1);
            check({tag, "_stall_sum"}, out_sum, held_sum);
            check({tag, "_stall_cout"}, out_cout, held_cout);
            check({tag, "_stall_in_ready"}, in_ready, 0);
        end
        check({tag, "_sum"}, out_sum, exp[W-1:0]);
        check({tag, "_cout"}, out_cout, exp[W]);
        check({tag, "_ovf"}, out_ovf, exp[W+1]);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_retired_valid"}, out_valid, 0);
        check({tag, "_retired_in_ready"}, in_ready, 1);
    endtask

    // ---------------- main test ----------------
    initial begin
        logic [W+1:0] e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           cyc;
        int           last_t;
        int           n_acc;
        int           n_res;
        bit           acc_now;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        // reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_out_cout", out_cout, 0);
        check("post_rst_out_ovf", out_ovf, 0);

        // table vectors; vector 0 also stalls and pulses in_valid while busy
        for (int i = 0; i < 8; i++) begin
            e = {ovf_exp(vecs[i].ovf), vecs[i].cout, vecs[i].sum};
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, e,
                   (i == 0) ? 5 : 0, i == 0);
        end

        // reset in the third RUN cycle of 0x12+0x34
        @(negedge clk);
        in_a     = 8'h12;
        in_b     = 8'h34;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_out_cout", out_cout, 0);
        check("midrst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        run_op("after_rst", 8'h01, 8'h02, 1'b0, {1'b0, 1'b0, 8'h03}, 0, 0);

        // randomized ops against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, ref_op(ra, rb, rs),
                   $urandom_range(0, 3), 1'($urandom));
        end

        // back-to-back: in_valid and out_ready held high for 4 operations
        exp_q.delete();
        n_acc  = 0;
        n_res  = 0;
        cyc    = 0;
        last_t = -1;
        @(negedge clk);
        out_ready = 1'b1;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        in_sub    = 1'($urandom);
        in_valid  = 1'b1;
        while (n_res < 4 && cyc < 80) begin
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                exp_q.push_back(ref_op(in_a, in_b, in_sub));
                n_acc++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("b2b_sum", out_sum, e[W-1:0]);
                    check("b2b_cout", out_cout, e[W]);
                    check("b2b_ovf", out_ovf, e[W+1]);
                end
                if (last_t >= 0) begin
                    check("b2b_spacing", cyc - last_t, 10);
                end
                last_t = cyc;
                n_res++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                if (n_acc == 4) begin
                    in_valid = 1'b0;
                end else begin
                    in_a   = W'($urandom);
                    in_b   = W'($urandom);
                    in_sub = 1'($urandom);
                end
            end
        end
        check("b2b_result_count", n_res, 4);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
